stopwatch_ctrl: RTL and testbench

Stopwatch counting engine that sits between the push-button conditioning stage (debounced one-pulse outputs) and the 7-segment scan controller. It counts 00.00–99.99 seconds in BCD from an internal prescaler and is controlled by start/stop, clear and lap pulses. It presents four registered BCD digits ready for direct connection to the scan controller's four inputs.

---
 rtl/stopwatch_ctrl_pkg.sv | 18 +
 rtl/stopwatch_ctrl_bcd_digit.sv | 26 ++
 rtl/stopwatch_ctrl.sv | 145 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and constants for the stopwatch counting engine.
package stopwatch_ctrl_pkg;

   localparam int BCD_BIT_WIDTH = 4;
   localparam logic [BCD_BIT_WIDTH-1:0] BCD_MAX = 4'd9;

   typedef enum logic [1:0] {
      SW_IDLE  = 2'd0,
      SW_RUN   = 2'd1,
      SW_PAUSE = 2'd2
   } sw_state_e;

   // Next value of a mod-10 digit; an out-of-range value recovers to zero.
   function automatic logic [BCD_BIT_WIDTH-1:0] bcd_next(input logic [BCD_BIT_WIDTH-1:0] v);
      return (v >= BCD_MAX) ? '0 : v + 1'b1;
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// bcd_digit: one mod-10 counter cell of the stopwatch carry chain.
// carry is combinational so a whole chain resolves in the same tick cycle.
module bcd_digit
   import stopwatch_ctrl_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     inc,
   output logic [BCD_BIT_WIDTH-1:0] q,
   output logic                     carry
);

   assign carry = inc && (q == BCD_MAX);

   // Digit register: clear has priority over increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         q <= '0;
      else if (clr)
         q <= '0;
      else if (inc)
         q <= bcd_next(q);
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: 00.00-99.99 s BCD stopwatch engine.
// Optional lap snapshot feature is built when STOPWATCH_LAP_EN is defined.
//
// state    | meaning
// ---------+--------------------------------------------------
// SW_IDLE  | count and prescaler at zero, waiting for start
// SW_RUN   | prescaler running, count advances every tick
// SW_PAUSE | count and prescaler residue held
module stopwatch_ctrl
   import stopwatch_ctrl_pkg::*;
#(
   parameter int TICK_DIV = 400000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pb_start,
   input  logic       pb_clear,
   input  logic       pb_lap,
   output logic [3:0] dig3,
   output logic [3:0] dig2,
   output logic [3:0] dig1,
   output logic [3:0] dig0,
   output logic       running,
   output logic       lap_active,
   output logic       overflow
);

   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

   sw_state_e state_q, state_d;
   logic [PW-1:0] presc_q;
   logic          tick;
   logic          clr_cnt;
   logic          lap_ok;
   logic [3:0]    q0, q1, q2, q3;
   logic          c0, c1, c2, c3;
   logic [15:0]   live;
   logic [15:0]   disp;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= SW_IDLE;
      else
         state_q <= state_d;
   end

   // Next state; clr_cnt flags every transition into IDLE.
   // In RUN a clear pulse is ignored, so start still wins there.
   always_comb begin
      state_d = state_q;
      clr_cnt = 1'b0;
      unique case (state_q)
         SW_IDLE: begin
            if (pb_clear)
               clr_cnt = 1'b1;
            else if (pb_start)
               state_d = SW_RUN;
         end
         SW_RUN: begin
            if (pb_start)
               state_d = SW_PAUSE;
         end
         SW_PAUSE: begin
            if (pb_clear) begin
               state_d = SW_IDLE;
               clr_cnt = 1'b1;
            end else if (pb_start) begin
               state_d = SW_RUN;
            end
         end
         default: begin
            state_d = SW_IDLE;
            clr_cnt = 1'b1;
         end
      endcase
   end

   // Lap is the lowest-priority pulse and only acts while running.
   assign lap_ok  = (state_q == SW_RUN) && pb_lap && !pb_start && !pb_clear;
   assign tick    = (state_q == SW_RUN) && (presc_q == TICK_LAST);
   assign running = (state_q == SW_RUN);

   // Prescaler: advances only in RUN, so its residue survives a pause.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         presc_q <= '0;
      else if (clr_cnt)
         presc_q <= '0;
      else if (state_q == SW_RUN)
         presc_q <= tick ? '0 : presc_q + 1'b1;
   end

   bcd_digit u_dig0 (.clk(clk), .rst_n(rst_n), .clr(clr_cnt), .inc(tick), .q(q0), .carry(c0));
   bcd_digit u_dig1 (.clk(clk), .rst_n(rst_n), .clr(clr_cnt), .inc(c0),   .q(q1), .carry(c1));
   bcd_digit u_dig2 (.clk(clk), .rst_n(rst_n), .clr(clr_cnt), .inc(c1),   .q(q2), .carry(c2));
   bcd_digit u_dig3 (.clk(clk), .rst_n(rst_n), .clr(clr_cnt), .inc(c2),   .q(q3), .carry(c3));

   assign live = {q3, q2, q1, q0};

   // Sticky wrap flag: carry out of the top digit means 99.99 rolled to 00.00.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         overflow <= 1'b0;
      else if (clr_cnt)
         overflow <= 1'b0;
      else if (c3)
         overflow <= 1'b1;
   end

`ifdef STOPWATCH_LAP_EN
   logic        lap_q;
   logic [15:0] snap_q;

   // Lap latch: first pulse freezes the display on the pre-edge count, second releases.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lap_q  <= 1'b0;
         snap_q <= '0;
      end else if (clr_cnt) begin
         lap_q  <= 1'b0;
      end else if (lap_ok) begin
         if (lap_q) begin
            lap_q  <= 1'b0;
         end else begin
            lap_q  <= 1'b1;
            snap_q <= live;
         end
      end
   end

   assign lap_active = lap_q;
   assign disp       = lap_q ? snap_q : live;
`else
   logic unused_lap;
   assign unused_lap = lap_ok;
   assign lap_active = 1'b0;
   assign disp       = live;
`endif

   // Display selects between two registers only; no input reaches it combinationally.
   assign {dig3, dig2, dig1, dig0} = disp;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with TICK_DIV = 4.
module tb_stopwatch_ctrl;

   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pb_start = 1'b0;
   logic       pb_clear = 1'b0;
   logic       pb_lap = 1'b0;
   logic [3:0] dig3, dig2, dig1, dig0;
   logic       running, lap_active, overflow;

   int checks = 0;
   int errors = 0;

   stopwatch_ctrl #(.TICK_DIV(TD)) dut (
      .clk(clk), .rst_n(rst_n),
      .pb_start(pb_start), .pb_clear(pb_clear), .pb_lap(pb_lap),
      .dig3(dig3), .dig2(dig2), .dig1(dig1), .dig0(dig0),
      .running(running), .lap_active(lap_active), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Reference model: mode 0 idle, 1 run, 2 pause; count in centiseconds.
   int m_mode, m_cnt, m_presc, m_snap;
   bit m_ov, m_lap;

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   function automatic logic [18:0] dut_out();
      return {dig3, dig2, dig1, dig0, running, lap_active, overflow};
   endfunction

   function automatic logic [18:0] model_out();
      return {to_bcd(m_lap ? m_snap : m_cnt), (m_mode == 1), m_lap, m_ov};
   endfunction

   task automatic model_reset();
      m_mode = 0; m_cnt = 0; m_presc = 0; m_snap = 0; m_ov = 0; m_lap = 0;
   endtask

   task automatic model_step(input bit s, input bit c, input bit l);
      int  old_cnt = m_cnt;
      bit  was_run = (m_mode == 1);
      if (was_run) begin
         m_presc++;
         if (m_presc == TD) begin
            m_presc = 0;
            m_cnt++;
            if (m_cnt == 10000) begin
               m_cnt = 0;
               m_ov = 1;
            end
         end
      end
`ifdef STOPWATCH_LAP_EN
      if (was_run && l && !s && !c) begin
         if (m_lap) m_lap = 0;
         else begin
            m_lap = 1;
            m_snap = old_cnt;
         end
      end
`else
      if (l && old_cnt < 0) m_lap = 0;
`endif
      if (c && !was_run) begin
         m_mode = 0; m_cnt = 0; m_presc = 0; m_ov = 0; m_lap = 0;
      end else if (s) begin
         m_mode = was_run ? 2 : 1;
      end
   endtask

   task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s actual=%h required=%h (dig3..0,run,lap,ovf)", name, act, exp);
      end
   endtask

   // One clock: pulses driven after the falling edge, outputs valid 1 unit after the rising edge.
   task automatic do_cycle(input bit s, input bit c, input bit l);
      @(negedge clk);
      pb_start = s; pb_clear = c; pb_lap = l;
      @(posedge clk);
      model_step(s, c, l);
      #1;
      pb_start = 0; pb_clear = 0; pb_lap = 0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 0;
      model_reset();
      #1;
      check("reset", dut_out(), 19'd0);
      @(negedge clk);
      rst_n = 1;
   endtask

   typedef struct {
      bit s; bit c; bit l;
      int wait_n;
      int exp_cnt;
      bit exp_run;
      bit exp_ov;
   } vec_t;

   localparam int NV = 30;
   vec_t tbl[NV];

   initial begin
      tbl[0]  = '{0,0,0,9,     0,   0,0};
      tbl[1]  = '{1,0,0,0,     0,   1,0};
      tbl[2]  = '{0,0,0,3,     1,   1,0};
      tbl[3]  = '{0,0,0,35,    10,  1,0};
      tbl[4]  = '{0,0,0,5,     11,  1,0};
      tbl[5]  = '{1,0,0,0,     11,  0,0};
      tbl[6]  = '{0,0,0,99,    11,  0,0};
      tbl[7]  = '{1,0,0,0,     11,  1,0};
      tbl[8]  = '{0,0,0,0,     12,  1,0};
      tbl[9]  = '{0,1,0,0,     12,  1,0};
      tbl[10] = '{0,0,0,1,     12,  1,0};
      tbl[11] = '{1,0,0,0,     13,  0,0};
      tbl[12] = '{0,1,0,0,     0,   0,0};
      tbl[13] = '{1,0,0,0,     0,   1,0};
      tbl[14] = '{0,0,0,39991, 9998,1,0};
      tbl[15] = '{0,0,0,3,     9999,1,0};
      tbl[16] = '{0,0,0,3,     0,   1,1};
      tbl[17] = '{0,0,0,39,    10,  1,1};
      tbl[18] = '{1,0,0,0,     10,  0,1};
      tbl[19] = '{0,1,0,0,     0,   0,0};
      tbl[20] = '{1,0,0,0,     0,   1,0};
      tbl[21] = '{0,0,0,7,     2,   1,0};
      tbl[22] = '{1,0,0,0,     2,   0,0};
      tbl[23] = '{1,1,0,0,     0,   0,0};
      tbl[24] = '{1,0,0,0,     0,   1,0};
      tbl[25] = '{0,0,0,3,     1,   1,0};
      tbl[26] = '{1,1,0,0,     1,   0,0};
      tbl[27] = '{0,0,0,5,     1,   0,0};
      tbl[28] = '{0,1,0,0,     0,   0,0};
      tbl[29] = '{0,1,0,0,     0,   0,0};

      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("por_reset", dut_out(), 19'd0);
      @(negedge clk);
      rst_n = 1;

      // Directed table: pulse cycle, idle cycles, then compare against hand values.
      for (int i = 0; i < NV; i++) begin
         do_cycle(tbl[i].s, tbl[i].c, tbl[i].l);
         for (int w = 0; w < tbl[i].wait_n; w++)
            do_cycle(0, 0, 0);
         check($sformatf("vec%0d", i), dut_out(),
               {to_bcd(tbl[i].exp_cnt), tbl[i].exp_run, 1'b0, tbl[i].exp_ov});
      end

      // Lap sequence: freeze at 00.12, count on to 00.20, release.
      apply_reset();
      do_cycle(1, 0, 0);
      repeat (48) do_cycle(0, 0, 0);
      check("lap_pre", dut_out(), {to_bcd(12), 1'b1, 1'b0, 1'b0});
      do_cycle(0, 0, 1);
`ifdef STOPWATCH_LAP_EN
      check("lap_set", dut_out(), {to_bcd(12), 1'b1, 1'b1, 1'b0});
`else
      check("lap_set", dut_out(), {to_bcd(12), 1'b1, 1'b0, 1'b0});
`endif
      repeat (31) do_cycle(0, 0, 0);
`ifdef STOPWATCH_LAP_EN
      check("lap_hold", dut_out(), {to_bcd(12), 1'b1, 1'b1, 1'b0});
`else
      check("lap_hold", dut_out(), {to_bcd(20), 1'b1, 1'b0, 1'b0});
`endif
      do_cycle(0, 0, 1);
      check("lap_release", dut_out(), {to_bcd(20), 1'b1, 1'b0, 1'b0});

      // Asynchronous reset in the middle of a clock period while running.
      repeat (9) do_cycle(0, 0, 0);
      #2;
      rst_n = 0;
      #1;
      check("async_reset", dut_out(), 19'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1;

      // Randomized pulses against the reference model.
      for (int n = 0; n < 4000; n++) begin
         bit s, c, l;
         s = ($urandom_range(0, 15) == 0);
         c = ($urandom_range(0, 11) == 0);
         l = ($urandom_range(0, 7) == 0);
         do_cycle(s, c, l);
         check($sformatf("rand%0d", n), dut_out(), model_out());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
